vga_bus_responder: RTL

- Memory-mapped bus responder that lets the core draw into the VGA framebuffer.
- Decodes a fixed address window on the core's I/O bus (bus_addr/bus_wdata/bus_we/bus_rdata) and accepts every write in one cycle, because the bus has no wait signal.
- Queues pixel writes in a FIFO and drains them to the framebuffer write port with a valid/ready handshake.
- Also offers a status register and a hardware full-frame fill command. Sits in top between core1 and vga_memory1, and supplies the vga_we/pixel/colour write path.

---
 rtl/vga_bus_responder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vga_bus_responder.sv
// rtl/vga_bus_responder.sv - core-bus responder feeding the VGA framebuffer write port
//
// Purpose: decodes a 16-byte register window on the core I/O bus, queues
// PIXEL writes in a FIFO, and drains them (or a full-frame FILL) to the
// framebuffer through a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   bus_addr   core bus byte address
//   bus_wdata  core bus write data
//   bus_we     one-cycle write strobe
//   bus_rdata  registered read data, 0 unless answering a read
//   fb_we      framebuffer write valid
//   fb_ready   framebuffer accepts the write this cycle
//   fb_addr    linear pixel index y*DISPLAY_WIDTH+x
//   fb_colour  RGB444 colour
module vga_bus_responder #(
    parameter int          DISPLAY_WIDTH  = 800,
    parameter int          DISPLAY_HEIGHT = 600,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_8000,
    parameter int          FIFO_DEPTH     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    output logic [31:0] bus_rdata,
    output logic        fb_we,
    input  logic        fb_ready,
    output logic [19:0] fb_addr,
    output logic [11:0] fb_colour
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] TOTAL     = 32'(DISPLAY_WIDTH * DISPLAY_HEIGHT);
    localparam logic [19:0] LAST_PIX  = 20'(DISPLAY_WIDTH * DISPLAY_HEIGHT - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FILL  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_range_err;
    logic          r_fill_req;
    logic [11:0]   r_fill_colour;
    logic [19:0]   r_fill_cnt;
    logic [31:0]   r_rdata;

    logic        w_sel;
    logic [1:0]  w_off;
    logic        w_pix_wr;
    logic        w_st_wr;
    logic        w_fill_wr;
    logic        w_rd;
    logic        w_range_bad;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_ovf_set;
    logic        w_rng_set;
    logic [31:0] w_head;
    logic [31:0] w_status;
    logic [7:0]  w_count8;
    logic        w_unused;

    assign w_sel     = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign w_off     = bus_addr[3:2];
    assign w_unused  = ^bus_addr[1:0];
    assign w_pix_wr  = w_sel && bus_we && (w_off == 2'd0);
    assign w_st_wr   = w_sel && bus_we && (w_off == 2'd1);
    assign w_fill_wr = w_sel && bus_we && (w_off == 2'd2) && (r_state != S_FILL);
    assign w_rd      = w_sel && !bus_we;

    assign w_range_bad = ({12'd0, bus_wdata[31:12]} >= TOTAL);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == DEPTH_C);
    assign w_pop       = (r_state == S_DRAIN) && fb_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push      = w_pix_wr && !w_range_bad && (!w_full || w_pop);
    assign w_ovf_set   = w_pix_wr && !w_range_bad && w_full && !w_pop;
    assign w_rng_set   = w_pix_wr && w_range_bad;
    assign w_head      = r_mem[r_rd_ptr];

    assign w_count8 = 8'(r_count);
    assign w_status = {16'd0, w_count8, 3'd0, r_range_err, (r_state != S_IDLE),
                       r_overflow, w_full, w_empty};

    assign bus_rdata = r_rdata;

    always_comb begin
        w_state_next = r_state;
        fb_we        = 1'b0;
        fb_addr      = '0;
        fb_colour    = '0;
        case (r_state)
            S_IDLE: begin
                if (r_fill_req) begin
                    w_state_next = S_FILL;
                end else if (!w_empty) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                fb_we     = 1'b1;
                fb_addr   = w_head[31:12];
                fb_colour = w_head[11:0];
                // Leave only on a completed handshake so fb_we never drops mid-transfer.
                if (fb_ready && (r_fill_req || (r_count == CW'(1) && !w_push))) begin
                    w_state_next = S_IDLE;
                end
            end
            S_FILL: begin
                fb_we     = 1'b1;
                fb_addr   = r_fill_cnt;
                fb_colour = r_fill_colour;
                if (fb_ready && (r_fill_cnt == LAST_PIX)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_range_err   <= 1'b0;
            r_fill_req    <= 1'b0;
            r_fill_colour <= '0;
            r_fill_cnt    <= '0;
            r_rdata       <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end

            // A new error event wins over a clear in the same cycle.
            r_overflow  <= w_ovf_set | (r_overflow & ~(w_st_wr & bus_wdata[2]));
            r_range_err <= w_rng_set | (r_range_err & ~(w_st_wr & bus_wdata[4]));

            if (r_state == S_IDLE && r_fill_req) begin
                r_fill_req <= 1'b0;
            end
            if (w_fill_wr) begin
                r_fill_req    <= 1'b1;
                r_fill_colour <= bus_wdata[11:0];
            end

            if (r_state == S_IDLE && w_state_next == S_FILL) begin
                r_fill_cnt <= '0;
            end else if (r_state == S_FILL && fb_ready) begin
                r_fill_cnt <= (r_fill_cnt == LAST_PIX) ? 20'd0 : r_fill_cnt + 20'd1;
            end

            if (w_rd && w_off == 2'd1) begin
                r_rdata <= w_status;
            end else begin
                r_rdata <= '0;
            end
        end
    end

endmodule
